clkdiv_sched: RTL and testbench

//  Time-shares one programmable clock divider among N requesters.

---
 rtl/clkdiv_sched.sv | 196 +++++++++++++++++++
 tb/tb_clkdiv_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: one programmable clock divider time-shared among N requesters.
// A round-robin arbiter hands the divider to one requester at a time. The owner
// gets cnt divided periods at ratio D = max(div, 2), then a one-cycle done pulse.
//
// Ports
//   clk          core clock
//   rst_n        asynchronous reset, active-high
//   i_req[N]     per-requester request level (dropping it mid-job aborts the job)
//   i_div[N*W]   divide ratio of requester i at [i*W +: W]
//   i_cnt[N*CW]  tick count of requester i at [i*CW +: CW]
//   o_gnt[N]     one-hot grant, held for the whole job
//   o_busy       divider owned (RUN or DONE)
//   o_tick       1-cycle strobe, once per divided period
//   o_clk_out    divided clock, high for the first (D+1)>>1 cycles of each period
//   o_done[N]    1-cycle completion pulse to the owner
//
// All outputs are registered. A zero-count job shows gnt and done together for
// its single DONE cycle; a normal job drops gnt on entering DONE.
module clkdiv_sched #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    i_req,
   input  logic [N*W-1:0]  i_div,
   input  logic [N*CW-1:0] i_cnt,
   output logic [N-1:0]    o_gnt,
   output logic            o_busy,
   output logic            o_tick,
   output logic            o_clk_out,
   output logic [N-1:0]    o_done
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t          r_state, w_state_d;
   logic [N-1:0]    r_gnt, w_gnt_d;
   logic [N-1:0]    r_done, w_done_d;
   logic            r_busy, w_busy_d;
   logic            r_tick, w_tick_d;
   logic            r_clk_out, w_clk_out_d;
   logic [W-1:0]    r_phase, w_phase_d;
   logic [W-1:0]    r_ratio, w_ratio_d;
   logic [CW-1:0]   r_rem, w_rem_d;
   logic [IW-1:0]   r_ptr, w_ptr_d;
   logic [IW-1:0]   r_owner, w_owner_d;

   logic [W-1:0]    w_div_arr [N];
   logic [CW-1:0]   w_cnt_arr [N];
   logic            w_found;
   logic [IW-1:0]   w_win;
   logic [IW:0]     w_sum;
   logic [N-1:0]    w_win_oh;
   logic [W-1:0]    w_eff;
   logic [CW-1:0]   w_cnt_sel;
   logic [W-1:0]    w_phase_nx;
   logic [W:0]      w_half;
   logic            w_tick_now;
   logic [IW-1:0]   w_ptr_nx;

   // Round-robin search: first set request scanning upward from r_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_div_arr[i] = i_div[i*W +: W];
         w_cnt_arr[i] = i_cnt[i*CW +: CW];
      end
      for (int unsigned j = 0; j < N; j++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(j);
         if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
         if (!w_found && i_req[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[IW-1:0];
         end
      end
   end

   assign w_win_oh   = N'(1) << w_win;
   assign w_eff      = (w_div_arr[w_win] < W'(2)) ? W'(2) : w_div_arr[w_win];
   assign w_cnt_sel  = w_cnt_arr[w_win];
   assign w_tick_now = (r_phase == r_ratio - W'(1));
   assign w_phase_nx = w_tick_now ? '0 : r_phase + W'(1);
   assign w_half     = ({1'b0, r_ratio} + (W+1)'(1)) >> 1;
   assign w_ptr_nx   = (r_owner == IW'(N-1)) ? '0 : r_owner + IW'(1);

   always_comb begin
      w_state_d   = r_state;
      w_gnt_d     = r_gnt;
      w_done_d    = '0;
      w_busy_d    = r_busy;
      w_tick_d    = 1'b0;
      w_clk_out_d = 1'b0;
      w_phase_d   = r_phase;
      w_ratio_d   = r_ratio;
      w_rem_d     = r_rem;
      w_ptr_d     = r_ptr;
      w_owner_d   = r_owner;
      unique case (r_state)
         StIdle: begin
            w_gnt_d  = '0;
            w_busy_d = 1'b0;
            if (w_found) begin
               // Ratio and count are frozen here for the lifetime of the job.
               w_owner_d = w_win;
               w_ratio_d = w_eff;
               w_rem_d   = w_cnt_sel;
               w_phase_d = '0;
               w_gnt_d   = w_win_oh;
               w_busy_d  = 1'b1;
               if (w_cnt_sel != '0) begin
                  w_state_d   = StRun;
                  w_clk_out_d = 1'b1;  // phase 0 is always in the high half
               end else begin
                  w_state_d = StDone;
                  w_done_d  = w_win_oh;
               end
            end
         end
         StRun: begin
            if (!i_req[r_owner]) begin
               // Abort: release immediately, no done pulse.
               w_state_d = StIdle;
               w_gnt_d   = '0;
               w_busy_d  = 1'b0;
               w_ptr_d   = w_ptr_nx;
               w_phase_d = '0;
               w_rem_d   = '0;
            end else if (w_tick_now && (r_rem == CW'(1))) begin
               w_state_d = StDone;
               w_gnt_d   = '0;
               w_done_d  = r_gnt;
               w_phase_d = '0;
               w_rem_d   = '0;
            end else begin
               // Outputs are registered, so they are derived from next phase.
               w_phase_d   = w_phase_nx;
               w_tick_d    = (w_phase_nx == r_ratio - W'(1));
               w_clk_out_d = ({1'b0, w_phase_nx} < w_half);
               if (w_tick_now) w_rem_d = r_rem - CW'(1);
            end
         end
         StDone: begin
            w_state_d = StIdle;
            w_gnt_d   = '0;
            w_busy_d  = 1'b0;
            w_ptr_d   = w_ptr_nx;
         end
         default: begin
            w_state_d = StIdle;
            w_gnt_d   = '0;
            w_busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state   <= StIdle;
         r_gnt     <= '0;
         r_done    <= '0;
         r_busy    <= 1'b0;
         r_tick    <= 1'b0;
         r_clk_out <= 1'b0;
         r_phase   <= '0;
         r_ratio   <= W'(2);
         r_rem     <= '0;
         r_ptr     <= '0;
         r_owner   <= '0;
      end else begin
         r_state   <= w_state_d;
         r_gnt     <= w_gnt_d;
         r_done    <= w_done_d;
         r_busy    <= w_busy_d;
         r_tick    <= w_tick_d;
         r_clk_out <= w_clk_out_d;
         r_phase   <= w_phase_d;
         r_ratio   <= w_ratio_d;
         r_rem     <= w_rem_d;
         r_ptr     <= w_ptr_d;
         r_owner   <= w_owner_d;
      end
   end

   assign o_gnt     = r_gnt;
   assign o_done    = r_done;
   assign o_busy    = r_busy;
   assign o_tick    = r_tick;
   assign o_clk_out = r_clk_out;

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: directed bench for clkdiv_sched (N=4, W=8, CW=8).
// Each cycle the output vector {gnt, busy, tick, clk_out, done} is sampled 1 ns
// after the rising edge and compared with a hand-derived expectation.
module tb_clkdiv_sched;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*W-1:0]  div;
   logic [N*CW-1:0] cnt;
   logic [N-1:0]    gnt;
   logic            busy;
   logic            tick;
   logic            clk_out;
   logic [N-1:0]    done;

   int n_run  = 0;
   int n_fail = 0;

   clkdiv_sched #(.N(N), .W(W), .CW(CW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req),
      .i_div     (div),
      .i_cnt     (cnt),
      .o_gnt     (gnt),
      .o_busy    (busy),
      .o_tick    (tick),
      .o_clk_out (clk_out),
      .o_done    (done)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ex(input logic [3:0] g, input logic b, input logic t,
                                      input logic c, input logic [3:0] d);
      return {g, b, t, c, d};
   endfunction

   function automatic logic [10:0] obs();
      return {gnt, busy, tick, clk_out, done};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
      n_run++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed {gnt,busy,tick,clk,done}=%b expected %b", tag, o, e);
      end
   endtask

   // Runs a job of C periods at ratio D for requester who, already requested.
   // Drops all requests during the DONE cycle, then checks the idle cycle.
   task automatic run_job(input string tag, input int who, input int d, input int c);
      logic [3:0] oh;
      oh = 4'(1) << who;
      for (int k = 1; k <= d*c; k++) begin
         cyc();
         chk($sformatf("%s c%0d", tag, k), obs(),
             ex(oh, 1'b1, (k % d) == 0, ((k-1) % d) < ((d+1)/2), 4'b0000));
      end
      cyc();
      chk({tag, " done"}, obs(), ex(4'b0000, 1'b1, 1'b0, 1'b0, oh));
      req = 4'b0000;
      cyc();
      chk({tag, " idle"}, obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
   endtask

   initial begin
      logic [3:0] oh;
      int         ord [2];
      rst_n = 1'b1;
      req   = '0;
      div   = '0;
      cnt   = '0;
      cyc();
      cyc();
      chk("reset", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));

      // div=5, cnt=3: 15 gnt cycles, ticks at 5/10/15, clk_out 3 high / 2 low.
      rst_n = 1'b0;
      req = 4'b0001;
      div[0 +: W] = 8'd5;
      cnt[0 +: CW] = 8'd3;
      for (int k = 1; k <= 15; k++) begin
         cyc();
         chk($sformatf("d5 c%0d", k), obs(),
             ex(4'b0001, 1'b1, (k % 5) == 0, ((k-1) % 5) < 3, 4'b0000));
         if (k == 3) begin
            // Must be ignored by the running job.
            div[0 +: W] = 8'd9;
            cnt[0 +: CW] = 8'd1;
         end
      end
      cyc();
      chk("d5 done", obs(), ex(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001));
      req = 4'b0000;
      cyc();
      chk("d5 idle", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));

      // div=0 and div=1 behave as div=2 (pointer now at 1, then 2).
      div[W +: W] = 8'd0;
      cnt[CW +: CW] = 8'd2;
      req = 4'b0010;
      run_job("div0", 1, 2, 2);
      div[2*W +: W] = 8'd1;
      cnt[2*CW +: CW] = 8'd2;
      req = 4'b0100;
      run_job("div1", 2, 2, 2);

      // cnt=0: single DONE cycle with gnt and done together, no ticks.
      div[3*W +: W] = 8'd7;
      cnt[3*CW +: CW] = 8'd0;
      req = 4'b1000;
      cyc();
      chk("cnt0 done", obs(), ex(4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000));
      req = 4'b0000;
      cyc();
      chk("cnt0 idle", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));

      // All four request: order 0,1,2,3, each 2 cycles, DONE + IDLE between.
      div = {4{8'd2}};
      cnt = {4{8'd1}};
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         oh = 4'(1) << k;
         cyc();
         chk($sformatf("rr%0d c1", k), obs(), ex(oh, 1'b1, 1'b0, 1'b1, 4'b0000));
         cyc();
         chk($sformatf("rr%0d c2", k), obs(), ex(oh, 1'b1, 1'b1, 1'b0, 4'b0000));
         cyc();
         chk($sformatf("rr%0d done", k), obs(), ex(4'b0000, 1'b1, 1'b0, 1'b0, oh));
         cyc();
         chk($sformatf("rr%0d idle", k), obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
      end
      req = 4'b1001;
      ord[0] = 0;
      ord[1] = 3;
      for (int k = 0; k < 2; k++) begin
         oh = 4'(1) << ord[k];
         cyc();
         chk($sformatf("rr9 %0d c1", ord[k]), obs(), ex(oh, 1'b1, 1'b0, 1'b1, 4'b0000));
         cyc();
         chk($sformatf("rr9 %0d c2", ord[k]), obs(), ex(oh, 1'b1, 1'b1, 1'b0, 4'b0000));
         cyc();
         chk($sformatf("rr9 %0d done", ord[k]), obs(), ex(4'b0000, 1'b1, 1'b0, 1'b0, oh));
         if (k == 1) req = 4'b0000;
         cyc();
         chk($sformatf("rr9 %0d idle", ord[k]), obs(),
             ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
      end

      // Abort: div=4, cnt=10, req0 dropped after 6 RUN cycles; req1 waits.
      div[0 +: W] = 8'd4;
      cnt[0 +: CW] = 8'd10;
      req = 4'b0011;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk($sformatf("abort c%0d", k), obs(),
             ex(4'b0001, 1'b1, k == 4, ((k-1) % 4) < 2, 4'b0000));
      end
      req = 4'b0010;
      cyc();
      chk("abort idle", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
      cyc();
      chk("abort next c1", obs(), ex(4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000));
      cyc();
      chk("abort next c2", obs(), ex(4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000));
      cyc();
      chk("abort next done", obs(), ex(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010));
      req = 4'b0000;
      cyc();
      chk("abort next idle", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));

      // Reset mid-RUN clears outputs without a clock edge; pointer returns to 0.
      div[0 +: W] = 8'd5;
      cnt[0 +: CW] = 8'd3;
      req = 4'b0001;
      cyc();
      cyc();
      chk("pre-rst c2", obs(), ex(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000));
      cyc();
      rst_n = 1'b1;
      #1;
      chk("async rst", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
      req = 4'b0011;
      cyc();
      chk("rst hold", obs(), ex(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000));
      rst_n = 1'b0;
      cyc();
      chk("post-rst gnt0", obs(), ex(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
